// File: rtl/hls_fp16_out_arb.sv
// Two-requester round-robin burst arbiter feeding a single registered fp16 output slot.
// Each grant carries up to len_q beats and is followed by one IDLE bubble before the next grant.
module hls_fp16_out_arb (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        chn_a_vld,
    output logic        chn_a_rdy,
    input  logic [15:0] chn_a_pd,
    input  logic        chn_b_vld,
    output logic        chn_b_rdy,
    input  logic [15:0] chn_b_pd,
    input  logic [3:0]  cfg_burst_len,
    output logic        chn_o_vld,
    input  logic        chn_o_rdy,
    output logic [15:0] chn_o_pd,
    output logic        chn_o_src,
    output logic        arb_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic        o_vld_q, o_vld_d;
    logic [15:0] o_pd_q, o_pd_d;
    logic        o_src_q, o_src_d;

    logic        slot_free;
    logic        accept_a;
    logic        accept_b;
    logic [3:0]  burst_len_eff;

    assign slot_free     = !o_vld_q || chn_o_rdy;
    assign chn_a_rdy     = (state_q == GRANT_A) && slot_free;
    assign chn_b_rdy     = (state_q == GRANT_B) && slot_free;
    assign accept_a      = chn_a_vld && chn_a_rdy;
    assign accept_b      = chn_b_vld && chn_b_rdy;
    assign burst_len_eff = (cfg_burst_len == 4'd0) ? 4'd1 : cfg_burst_len;

    assign chn_o_vld = o_vld_q;
    assign chn_o_pd  = o_pd_q;
    assign chn_o_src = o_src_q;
    assign arb_busy  = (state_q != IDLE) || o_vld_q;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cnt_d   = cnt_q;
        len_d   = len_q;

        case (state_q)
            IDLE: begin
                if (chn_a_vld && (!chn_b_vld || !prio_q)) begin
                    state_d = GRANT_A;
                    cnt_d   = 4'd0;
                    len_d   = burst_len_eff;
                end else if (chn_b_vld) begin
                    state_d = GRANT_B;
                    cnt_d   = 4'd0;
                    len_d   = burst_len_eff;
                end
            end
            GRANT_A: begin
                // A stalled output slot freezes the burst; only a free slot with no data ends it early.
                if (slot_free) begin
                    if (chn_a_vld) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == len_q - 4'd1) begin
                            state_d = IDLE;
                            prio_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        prio_d  = 1'b1;
                    end
                end
            end
            GRANT_B: begin
                if (slot_free) begin
                    if (chn_b_vld) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == len_q - 4'd1) begin
                            state_d = IDLE;
                            prio_d  = 1'b0;
                        end
                    end else begin
                        state_d = IDLE;
                        prio_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        o_vld_d = o_vld_q;
        o_pd_d  = o_pd_q;
        o_src_d = o_src_q;

        if (accept_a) begin
            o_vld_d = 1'b1;
            o_pd_d  = chn_a_pd;
            o_src_d = 1'b0;
        end else if (accept_b) begin
            o_vld_d = 1'b1;
            o_pd_d  = chn_b_pd;
            o_src_d = 1'b1;
        end else if (chn_o_rdy) begin
            o_vld_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            cnt_q   <= 4'd0;
            len_q   <= 4'd1;
            o_vld_q <= 1'b0;
            o_pd_q  <= 16'd0;
            o_src_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            o_vld_q <= o_vld_d;
            o_pd_q  <= o_pd_d;
            o_src_q <= o_src_d;
        end
    end

endmodule

// File: tb/tb_hls_fp16_out_arb.sv
// Bench for hls_fp16_out_arb: cycle vectors, hand-written burst corner cases and a
// randomized per-source ordering scoreboard.
module tb_hls_fp16_out_arb;

    logic        clk;
    logic        rst;
    logic        a_vld, b_vld, o_rdy;
    logic [15:0] a_pd, b_pd;
    logic [3:0]  cfg_len;
    logic        a_rdy, b_rdy, o_vld, o_src, busy;
    logic [15:0] o_pd;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        rst;
        logic        a_vld;
        logic        b_vld;
        logic [15:0] a_pd;
        logic [15:0] b_pd;
        logic [3:0]  len;
        logic        o_rdy;
        logic        e_a_rdy;
        logic        e_b_rdy;
        logic        e_vld;
        logic [15:0] e_pd;
        logic        e_src;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    hls_fp16_out_arb dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .chn_a_vld      (a_vld),
        .chn_a_rdy      (a_rdy),
        .chn_a_pd       (a_pd),
        .chn_b_vld      (b_vld),
        .chn_b_rdy      (b_rdy),
        .chn_b_pd       (b_pd),
        .cfg_burst_len  (cfg_len),
        .chn_o_vld      (o_vld),
        .chn_o_rdy      (o_rdy),
        .chn_o_pd       (o_pd),
        .chn_o_src      (o_src),
        .arb_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic r, input logic av, input logic bv, input logic [15:0] ap,
                          input logic [15:0] bp, input logic [3:0] l, input logic orr,
                          input logic ea, input logic eb, input logic ev, input logic [15:0] ep,
                          input logic es, input logic ebz);
        vec_t v;
        v.rst = r; v.a_vld = av; v.b_vld = bv; v.a_pd = ap; v.b_pd = bp; v.len = l; v.o_rdy = orr;
        v.e_a_rdy = ea; v.e_b_rdy = eb; v.e_vld = ev; v.e_pd = ep; v.e_src = es; v.e_busy = ebz;
        vecs.push_back(v);
    endtask

    // Inputs of a record are present at the edge; the expectations describe the cycle after it.
    task automatic applyStimulus(input vec_t v, input int idx);
        rst = v.rst; a_vld = v.a_vld; b_vld = v.b_vld; a_pd = v.a_pd; b_pd = v.b_pd;
        cfg_len = v.len; o_rdy = v.o_rdy;
        step();
        checkOutput($sformatf("vec%0d a_rdy", idx), 16'(a_rdy), 16'(v.e_a_rdy));
        checkOutput($sformatf("vec%0d b_rdy", idx), 16'(b_rdy), 16'(v.e_b_rdy));
        checkOutput($sformatf("vec%0d o_vld", idx), 16'(o_vld), 16'(v.e_vld));
        checkOutput($sformatf("vec%0d o_pd", idx), o_pd, v.e_pd);
        checkOutput($sformatf("vec%0d o_src", idx), 16'(o_src), 16'(v.e_src));
        checkOutput($sformatf("vec%0d busy", idx), 16'(busy), 16'(v.e_busy));
    endtask

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] a_seq, b_seq, exp_pd;

    initial begin
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; a_pd = 16'h0; b_pd = 16'h0;
        cfg_len = 4'd1; o_rdy = 1'b1;

        // len=2, both requesters streaming: A,A,bubble,B,B,bubble,A
        addVec(1, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  0, 0, 0, 16'h0000, 0, 0);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  1, 0, 0, 16'h0000, 0, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  1, 0, 1, 16'h3C00, 0, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  0, 0, 1, 16'h3C00, 0, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  0, 1, 0, 16'h3C00, 0, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  0, 1, 1, 16'h4000, 1, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  0, 0, 1, 16'h4000, 1, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  1, 0, 0, 16'h4000, 1, 1);
        addVec(0, 1, 1, 16'h3C00, 16'h4000, 4'd2, 1,  1, 0, 1, 16'h3C00, 0, 1);
        // len=0 behaves as 1, A only: one beat every two cycles, then idle
        addVec(1, 1, 0, 16'h1111, 16'h0000, 4'd0, 1,  0, 0, 0, 16'h0000, 0, 0);
        addVec(0, 1, 0, 16'h1111, 16'h0000, 4'd0, 1,  1, 0, 0, 16'h0000, 0, 1);
        addVec(0, 1, 0, 16'h1111, 16'h0000, 4'd0, 1,  0, 0, 1, 16'h1111, 0, 1);
        addVec(0, 1, 0, 16'h2222, 16'h0000, 4'd0, 1,  1, 0, 0, 16'h1111, 0, 1);
        addVec(0, 1, 0, 16'h2222, 16'h0000, 4'd0, 1,  0, 0, 1, 16'h2222, 0, 1);
        addVec(0, 0, 0, 16'h2222, 16'h0000, 4'd0, 1,  0, 0, 0, 16'h2222, 0, 0);

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // len=4, B only, output stalled for 5 cycles after the first beat
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b1; cfg_len = 4'd4;
        step();
        rst = 1'b0; b_vld = 1'b1; b_pd = 16'hB001;
        step();
        checkOutput("bp grant b_rdy", 16'(b_rdy), 16'd1);
        step();
        checkOutput("bp beat1 pd", o_pd, 16'hB001);
        checkOutput("bp beat1 src", 16'(o_src), 16'd1);
        o_rdy = 1'b0; b_pd = 16'hB002; cfg_len = 4'd1;
        #1;
        checkOutput("bp stall b_rdy", 16'(b_rdy), 16'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput($sformatf("bp hold%0d pd", i), o_pd, 16'hB001);
            checkOutput($sformatf("bp hold%0d vld", i), 16'(o_vld), 16'd1);
            checkOutput($sformatf("bp hold%0d b_rdy", i), 16'(b_rdy), 16'd0);
        end
        o_rdy = 1'b1;
        #1;
        checkOutput("bp resume b_rdy", 16'(b_rdy), 16'd1);
        step();
        checkOutput("bp beat2 pd", o_pd, 16'hB002);
        b_pd = 16'hB003;
        step();
        checkOutput("bp beat3 pd", o_pd, 16'hB003);
        checkOutput("bp beat3 b_rdy", 16'(b_rdy), 16'd1);
        b_pd = 16'hB004;
        step();
        checkOutput("bp beat4 pd", o_pd, 16'hB004);
        checkOutput("bp burst end b_rdy", 16'(b_rdy), 16'd0);

        // len=8, A drops valid after 3 beats while B waits
        rst = 1'b1; b_vld = 1'b0; cfg_len = 4'd8;
        step();
        rst = 1'b0; a_vld = 1'b1; b_vld = 1'b1; a_pd = 16'hA001; b_pd = 16'hB101;
        step();
        checkOutput("early grant a_rdy", 16'(a_rdy), 16'd1);
        checkOutput("early grant b_rdy", 16'(b_rdy), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput($sformatf("early a beat%0d pd", i), o_pd, 16'hA001 + 16'(i));
            checkOutput($sformatf("early a beat%0d src", i), 16'(o_src), 16'd0);
            a_pd = 16'hA002 + 16'(i);
        end
        a_vld = 1'b0;
        step();
        checkOutput("early bubble a_rdy", 16'(a_rdy), 16'd0);
        checkOutput("early bubble b_rdy", 16'(b_rdy), 16'd0);
        checkOutput("early bubble vld", 16'(o_vld), 16'd0);
        checkOutput("early bubble busy", 16'(busy), 16'd0);
        step();
        checkOutput("early b grant b_rdy", 16'(b_rdy), 16'd1);
        step();
        checkOutput("early b beat pd", o_pd, 16'hB101);
        checkOutput("early b beat src", 16'(o_src), 16'd1);

        // Reset in the middle of the B burst with a beat in flight
        rst = 1'b1;
        step();
        checkOutput("midrst vld", 16'(o_vld), 16'd0);
        checkOutput("midrst pd", o_pd, 16'h0000);
        checkOutput("midrst a_rdy", 16'(a_rdy), 16'd0);
        checkOutput("midrst b_rdy", 16'(b_rdy), 16'd0);
        checkOutput("midrst busy", 16'(busy), 16'd0);
        rst = 1'b0; a_vld = 1'b1; b_vld = 1'b1;
        step();
        checkOutput("postrst a_rdy", 16'(a_rdy), 16'd1);
        checkOutput("postrst b_rdy", 16'(b_rdy), 16'd0);

        // Random traffic: per-source order, no loss or duplication
        rst = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
        step();
        rst = 1'b0;
        a_seq = 16'h0000;
        b_seq = 16'h8000;
        for (int c = 0; c < 3010; c++) begin
            if (c < 3000) begin
                a_vld = ($urandom_range(0, 9) < 7);
                b_vld = ($urandom_range(0, 9) < 7);
                o_rdy = ($urandom_range(0, 9) < 6);
            end else begin
                a_vld = 1'b0;
                b_vld = 1'b0;
                o_rdy = 1'b1;
            end
            cfg_len = 4'($urandom_range(1, 15));
            a_pd = a_seq;
            b_pd = b_seq;
            #1;
            checkOutput("rand single grant", 16'(a_rdy & b_rdy), 16'd0);
            if (o_vld && o_rdy) begin
                if (o_src == 1'b0) begin
                    if (qa.size() == 0) begin
                        checkOutput("rand spurious a", o_pd, 16'hFFFF);
                    end else begin
                        exp_pd = qa.pop_front();
                        checkOutput("rand a order", o_pd, exp_pd);
                    end
                end else begin
                    if (qb.size() == 0) begin
                        checkOutput("rand spurious b", o_pd, 16'hFFFF);
                    end else begin
                        exp_pd = qb.pop_front();
                        checkOutput("rand b order", o_pd, exp_pd);
                    end
                end
            end
            if (a_vld && a_rdy) begin
                qa.push_back(a_pd);
                a_seq = a_seq + 16'd1;
            end
            if (b_vld && b_rdy) begin
                qb.push_back(b_pd);
                b_seq = b_seq + 16'd1;
            end
            step();
        end
        checkOutput("rand a lost", 16'(qa.size()), 16'd0);
        checkOutput("rand b lost", 16'(qb.size()), 16'd0);
        checkOutput("rand a traffic", 16'(a_seq != 16'h0000), 16'd1);
        checkOutput("rand b traffic", 16'(b_seq != 16'h8000), 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
